// File: rtl/rv0_stage_fifo_pkg.sv
// Shared types and helpers for the rv0 inter-stage elastic buffer.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package rv0_stage_fifo_pkg;

  // Packed stage-buffer payload carried between pipeline stages.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] insn;
  } stage_payload_t;

  localparam int STAGE_PAYLOAD_W = $bits(stage_payload_t);

  // True when n is a power of two and at least 2.
  function automatic bit is_pow2_ge2(input int n);
    return (n >= 2) && ((n & (n - 1)) == 0);
  endfunction

endpackage

// File: rtl/rv0_stage_fifo.sv
// Elastic DEPTH-entry buffer between rv0 pipeline stages, with optional empty fall-through and flush.
// Latency: 1 cycle in->out, or 0 cycles when empty and FALLTHROUGH=1.
// Backpressure: in_ready_o = ~full from registered state only; out_ready_i never reaches in_ready_o.
module rv0_stage_fifo
  import rv0_stage_fifo_pkg::*;
#(
  parameter int PAYLOAD_W   = STAGE_PAYLOAD_W,
  parameter int DEPTH       = 2,
  parameter bit FALLTHROUGH = 1'b0
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         flush_i,
  input  logic                         in_valid_i,
  output logic                         in_ready_o,
  input  logic [PAYLOAD_W-1:0]         in_data_i,
  output logic                         out_valid_o,
  input  logic                         out_ready_i,
  output logic [PAYLOAD_W-1:0]         out_data_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o,
  output logic                         full_o,
  output logic                         empty_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  // Pointers wrap naturally, so DEPTH must be a power of two.
  if (!is_pow2_ge2(DEPTH)) begin : g_depth_check
    $error("rv0_stage_fifo: DEPTH must be a power of two and >= 2");
  end

  logic [PAYLOAD_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]     wr_ptr;
  logic [PTR_W-1:0]     rd_ptr;
  logic [CNT_W-1:0]     count;

  logic empty;
  logic full;
  logic bypass;
  logic push;
  logic pop;
  logic wr_en;
  logic rd_adv;

  // Status flags and handshake decode, all derived from registered occupancy.
  always_comb begin
    empty  = (count == '0);
    full   = (count == CNT_W'(DEPTH));
    bypass = FALLTHROUGH && empty;

    in_ready_o = ~full;

    // Flush suppresses delivery in the redirect cycle.
    if (flush_i) begin
      out_valid_o = 1'b0;
    end else if (empty) begin
      out_valid_o = FALLTHROUGH ? in_valid_i : 1'b0;
    end else begin
      out_valid_o = 1'b1;
    end

    out_data_o = bypass ? in_data_i : mem[rd_ptr];

    push = in_valid_i & in_ready_o & ~flush_i;
    pop  = out_valid_o & out_ready_i;

    // A payload that falls straight through is never stored.
    wr_en  = push & ~(bypass & pop);
    rd_adv = pop & ~empty;

    count_o = count;
    full_o  = full;
    empty_o = empty;
  end

  // Storage array, pointers and occupancy.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (flush_i) begin
      // Contents stay; only the bookkeeping is cleared.
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) begin
        mem[wr_ptr] <= in_data_i;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (rd_adv) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({wr_en, rd_adv})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_rv0_stage_fifo.sv
// Scoreboard bench for rv0_stage_fifo across three configurations.
// Latency: checks both 1-cycle and 0-cycle (fall-through) paths.
// Backpressure: exercises full, toggling out_ready and flush.
module tb_rv0_stage_fifo;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  // Index 0: DEPTH=4 FT=0, index 1: DEPTH=2 FT=0, index 2: DEPTH=2 FT=1.
  logic        in_valid  [3];
  logic        out_ready [3];
  logic        flush     [3];
  logic [63:0] in_data   [3];
  logic        in_ready  [3];
  logic        out_valid [3];
  logic        full      [3];
  logic        empty     [3];
  logic [63:0] out_data  [3];
  logic [2:0]  count_a;
  logic [1:0]  count_b;
  logic [1:0]  count_c;

  rv0_stage_fifo #(.PAYLOAD_W(64), .DEPTH(4), .FALLTHROUGH(1'b0)) u_a (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush[0]),
    .in_valid_i(in_valid[0]), .in_ready_o(in_ready[0]), .in_data_i(in_data[0]),
    .out_valid_o(out_valid[0]), .out_ready_i(out_ready[0]), .out_data_o(out_data[0]),
    .count_o(count_a), .full_o(full[0]), .empty_o(empty[0])
  );

  rv0_stage_fifo #(.PAYLOAD_W(64), .DEPTH(2), .FALLTHROUGH(1'b0)) u_b (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush[1]),
    .in_valid_i(in_valid[1]), .in_ready_o(in_ready[1]), .in_data_i(in_data[1]),
    .out_valid_o(out_valid[1]), .out_ready_i(out_ready[1]), .out_data_o(out_data[1]),
    .count_o(count_b), .full_o(full[1]), .empty_o(empty[1])
  );

  rv0_stage_fifo #(.PAYLOAD_W(64), .DEPTH(2), .FALLTHROUGH(1'b1)) u_c (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush[2]),
    .in_valid_i(in_valid[2]), .in_ready_o(in_ready[2]), .in_data_i(in_data[2]),
    .out_valid_o(out_valid[2]), .out_ready_i(out_ready[2]), .out_data_o(out_data[2]),
    .count_o(count_c), .full_o(full[2]), .empty_o(empty[2])
  );

  int passed = 0;
  int total  = 0;
  int mcnt      [3];
  int delivered [3];
  logic [63:0] q0 [$];
  logic [63:0] q1 [$];
  logic [63:0] q2 [$];
  string nm [5] = '{"in_ready", "out_valid", "count", "full", "empty"};

  function automatic int dut_count(input int sel);
    case (sel)
      0:       return int'(count_a);
      1:       return int'(count_b);
      default: return int'(count_c);
    endcase
  endfunction

  // One clock of stimulus on instance sel; checks flags against the model,
  // compares popped data against the scoreboard, pushes accepted payloads.
  task automatic drive_cycle(input int sel, input logic v, input logic [63:0] d,
                             input logic r, input logic f);
    int dep;
    bit ft, exp_rdy, exp_ov, pu, po;
    logic [63:0] exp_d;
    int got [5];
    int want[5];
    @(negedge clk);
    in_valid[sel] = v; in_data[sel] = d; out_ready[sel] = r; flush[sel] = f;
    #1;
    dep = (sel == 0) ? 4 : 2;
    ft  = (sel == 2);
    exp_rdy = (mcnt[sel] < dep);
    exp_ov  = !f && (mcnt[sel] > 0 || (ft && v));
    got[0] = int'(in_ready[sel]);  want[0] = int'(exp_rdy);
    got[1] = int'(out_valid[sel]); want[1] = int'(exp_ov);
    got[2] = dut_count(sel);       want[2] = mcnt[sel];
    got[3] = int'(full[sel]);      want[3] = int'(mcnt[sel] == dep);
    got[4] = int'(empty[sel]);     want[4] = int'(mcnt[sel] == 0);
    for (int i = 0; i < 5; i++) begin
      total++;
      if (got[i] !== want[i])
        $display("FAIL %s inst%0d t=%0t: got %0d expected %0d", nm[i], sel, $time, got[i], want[i]);
      else
        passed++;
    end
    pu = v && exp_rdy && !f;
    po = exp_ov && r;
    if (po) begin
      exp_d = d;
      if (mcnt[sel] > 0) begin
        case (sel)
          0:       exp_d = q0.pop_front();
          1:       exp_d = q1.pop_front();
          default: exp_d = q2.pop_front();
        endcase
      end
      total++;
      if (out_data[sel] !== exp_d)
        $display("FAIL out_data inst%0d t=%0t: got %0h expected %0h", sel, $time, out_data[sel], exp_d);
      else
        passed++;
      delivered[sel]++;
    end
    if (pu && !(po && mcnt[sel] == 0)) begin
      case (sel)
        0:       q0.push_back(d);
        1:       q1.push_back(d);
        default: q2.push_back(d);
      endcase
    end
    if (f) begin
      mcnt[sel] = 0;
      case (sel)
        0:       q0.delete();
        1:       q1.delete();
        default: q2.delete();
      endcase
    end else begin
      mcnt[sel] = mcnt[sel] + int'(pu) - int'(po);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int s = 0; s < 3; s++) begin
      in_valid[s] = 1'b0; out_ready[s] = 1'b0; flush[s] = 1'b0; in_data[s] = '0;
      mcnt[s] = 0; delivered[s] = 0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    for (int s = 0; s < 3; s++) begin
      total++;
      if (out_data[s] !== 64'h0 || out_valid[s] !== 1'b0 || in_ready[s] !== 1'b1)
        $display("FAIL reset_outputs inst%0d: got data=%0h vld=%0b rdy=%0b expected 0/0/1",
                 s, out_data[s], out_valid[s], in_ready[s]);
      else
        passed++;
      drive_cycle(s, 1'b0, 64'h0, 1'b0, 1'b0);
    end
  endtask

  task automatic test_fill_drain();
    int start;
    start = delivered[0];
    for (int i = 0; i < 4; i++) drive_cycle(0, 1'b1, 64'hA + 64'(i), 1'b0, 1'b0);
    drive_cycle(0, 1'b1, 64'hE, 1'b0, 1'b0);   // offered while full: must be refused
    total++;
    if (full[0] !== 1'b1 || in_ready[0] !== 1'b0)
      $display("FAIL full_flag: got full=%0b rdy=%0b expected 1/0", full[0], in_ready[0]);
    else
      passed++;
    for (int i = 0; i < 4; i++) drive_cycle(0, 1'b0, 64'h0, 1'b1, 1'b0);
    drive_cycle(0, 1'b0, 64'h0, 1'b0, 1'b0);
    total++;
    if (delivered[0] - start !== 4 || empty[0] !== 1'b1)
      $display("FAIL drain_count: got %0d empty=%0b expected 4 empty=1", delivered[0] - start, empty[0]);
    else
      passed++;
  endtask

  task automatic test_wrap();
    int idx, start;
    bit acc;
    idx = 0;
    start = delivered[1];
    for (int cyc = 0; cyc < 60 && (delivered[1] - start) < 10; cyc++) begin
      acc = (idx < 10) && (mcnt[1] < 2);
      drive_cycle(1, idx < 10, 64'h100 + 64'(idx), (cyc % 2) == 0, 1'b0);
      if (acc) idx++;
    end
    drive_cycle(1, 1'b0, 64'h0, 1'b0, 1'b0);
    total++;
    if (delivered[1] - start !== 10 || q1.size() !== 0)
      $display("FAIL wrap_delivered: got %0d left %0d expected 10 left 0", delivered[1] - start, q1.size());
    else
      passed++;
  endtask

  task automatic test_fallthrough();
    drive_cycle(2, 1'b1, 64'h55, 1'b1, 1'b0);  // passes through, never stored
    drive_cycle(2, 1'b1, 64'h66, 1'b0, 1'b0);  // stored
    drive_cycle(2, 1'b1, 64'h77, 1'b1, 1'b0);  // pop 0x66, store 0x77
    drive_cycle(2, 1'b0, 64'h0, 1'b1, 1'b0);   // pop 0x77
    drive_cycle(2, 1'b0, 64'h0, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    drive_cycle(0, 1'b1, 64'h200, 1'b0, 1'b0);
    for (int i = 1; i < 9; i++) drive_cycle(0, 1'b1, 64'h200 + 64'(i), 1'b1, 1'b0);
    drive_cycle(0, 1'b0, 64'h0, 1'b1, 1'b0);
    drive_cycle(0, 1'b0, 64'h0, 1'b0, 1'b0);
  endtask

  task automatic test_flush();
    for (int i = 0; i < 3; i++) drive_cycle(0, 1'b1, 64'h31 + 64'(i), 1'b0, 1'b0);
    drive_cycle(0, 1'b1, 64'hDEAD, 1'b1, 1'b1);
    drive_cycle(0, 1'b0, 64'h0, 1'b0, 1'b0);
    drive_cycle(0, 1'b1, 64'h77, 1'b0, 1'b0);
    drive_cycle(0, 1'b0, 64'h0, 1'b1, 1'b0);   // must deliver 0x77, not 0xDEAD or 0x31
    drive_cycle(0, 1'b0, 64'h0, 1'b0, 1'b0);
    // Flush while empty on the fall-through instance: nothing escapes.
    drive_cycle(2, 1'b1, 64'h99, 1'b1, 1'b1);
    drive_cycle(2, 1'b0, 64'h0, 1'b0, 1'b0);
  endtask

  task automatic test_async_reset();
    drive_cycle(0, 1'b1, 64'h41, 1'b0, 1'b0);
    drive_cycle(0, 1'b1, 64'h42, 1'b0, 1'b0);
    @(negedge clk);
    in_valid[0] = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (count_a !== 3'd0 || empty[0] !== 1'b1 || full[0] !== 1'b0 || in_ready[0] !== 1'b1 ||
        out_valid[0] !== 1'b0 || out_data[0] !== 64'h0)
      $display("FAIL async_reset: got cnt=%0d e=%0b f=%0b rdy=%0b vld=%0b data=%0h expected 0/1/0/1/0/0",
               count_a, empty[0], full[0], in_ready[0], out_valid[0], out_data[0]);
    else
      passed++;
    for (int s = 0; s < 3; s++) mcnt[s] = 0;
    q0.delete(); q1.delete(); q2.delete();
    @(negedge clk);
    rst_n = 1'b1;
    drive_cycle(0, 1'b0, 64'h0, 1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_wrap();
    test_fallthrough();
    test_back_to_back();
    test_flush();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
